dyn_text_line: RTL and testbench

Pipelined text overlay on the 26-bit RGB stream. Draws a row of NCHARS characters at (pos_x, pos_y). Each font pixel is scaled by 2^SCALE_LOG2, and characters come from an internal, writable text buffer. The block sits in the RGB stream chain and shares the external 8x8 font ROM (2048x8) through an addr_rom/gline port. It is the multi-character, buffered, reset-aware successor of the single-character overlay.

---
 rtl/dyn_text_pkg.sv | 37 +++
 rtl/dyn_text_line_if.sv | 30 +++
 rtl/dyn_text_buf.sv | 34 +++
 rtl/dyn_text_line.sv | 199 +++++++++++++++++++
 tb/tb_dyn_text_line.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dyn_text_pkg.sv
// dyn_text_pkg: shared definitions for the dyn_text_line text overlay.
//   - Stream field positions of the 26-bit RGB stream and a packed struct view.
//   - Glyph geometry and font ROM address width.
//   - idx_w(): width of a character index (at least 1 bit).
package dyn_text_pkg;

    localparam int STREAM_W = 26;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 8;
    localparam int ROM_AW   = 11;

    // Stream field positions
    localparam int ACTIVE = 0;
    localparam int VS     = 1;
    localparam int HS     = 2;
    localparam int YC_LO  = 3;
    localparam int YC_HI  = 12;
    localparam int XC_LO  = 13;
    localparam int XC_HI  = 22;
    localparam int RGB_LO = 23;
    localparam int RGB_HI = 25;

    // Packed view of the stream; first member is the MSB end.
    typedef struct packed {
        logic [2:0] rgb;
        logic [9:0] xc;
        logic [9:0] yc;
        logic       hs;
        logic       vs;
        logic       active;
    } stream_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dyn_text_line_if.sv
// dyn_text_line_if: text buffer write port and shared font ROM port.
//   wr_en    text buffer write strobe (single-cycle, no acknowledge)
//   wr_addr  character index to write (IW bits)
//   wr_char  character code
//   addr_rom font ROM address {char, glyph_row}, driven by the overlay
//   gline    ROM row data, gline[0] = leftmost pixel, valid one cycle after addr_rom
// Handshake: there is no valid/ready pair. A write takes effect on the clock
// edge where wr_en is high; the ROM is a fixed one-cycle synchronous read.
// master = writer/ROM side, slave = the overlay block.
interface dyn_text_line_if
    import dyn_text_pkg::*;
#(
    parameter int IW = 4
);
    logic              wr_en;
    logic [IW-1:0]     wr_addr;
    logic [7:0]        wr_char;
    logic [ROM_AW-1:0] addr_rom;
    logic [0:7]        gline;

    modport master (
        output wr_en, wr_addr, wr_char, gline,
        input  addr_rom
    );

    modport slave (
        input  wr_en, wr_addr, wr_char, gline,
        output addr_rom
    );
endinterface

// File: rtl/dyn_text_buf.sv
// dyn_text_buf: NCHARS x 8 character register file.
//   clk, rst_n  clock / asynchronous active-low reset (cells reset to FILL_CHAR)
//   wr_en, wr_addr, wr_char  synchronous write; indices >= NCHARS are ignored
//   rd_addr, rd_char         asynchronous read (old data during a same-cycle write)
module dyn_text_buf #(
    parameter int         NCHARS    = 16,
    parameter int         IW        = 4,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic [IW-1:0] rd_addr,
    output logic [7:0]    rd_char
);
    logic [7:0] mem [NCHARS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHARS; i++) begin
                mem[i] <= FILL_CHAR;
            end
        end else if (wr_en && (32'(wr_addr) < 32'(NCHARS))) begin
            mem[wr_addr] <= wr_char;
        end
    end

    // Out-of-range reads only happen for pixels outside the line, whose
    // character is never used.
    assign rd_char = (32'(rd_addr) < 32'(NCHARS)) ? mem[rd_addr] : FILL_CHAR;

endmodule

// File: rtl/dyn_text_line.sv
// dyn_text_line: pipelined multi-character text overlay on the 26-bit RGB stream.
// Draws NCHARS characters from an internal text buffer at (pos_x, pos_y), each
// font pixel scaled to 2^SCALE_LOG2 screen pixels, using an external shared
// 8x8 font ROM. Fixed 3-cycle latency, no stall.
// Ports:
//   px_clk, rst_n  pixel clock, asynchronous active-low reset
//   RGBStr_i       input stream [0] Active [1] VS [2] HS [12:3] YC [22:13] XC [25:23] RGB
//   pos_x, pos_y   top-left corner of the line
//   bus            dyn_text_line_if.slave: text write port + font ROM port
//   RGBStr_o       output stream
// Optional build macro DYN_TEXT_CURSOR_EN adds cursor_idx / cursor_on inputs and
// a blinking (colour-swapped) cursor cell driven by a VS frame counter.
module dyn_text_line
    import dyn_text_pkg::*;
#(
    parameter int         NCHARS     = 16,
    parameter int         SCALE_LOG2 = 1,
    parameter logic [2:0] COLOR_FG   = 3'b110,
    parameter logic [2:0] COLOR_BG   = 3'b001,
    parameter int         ALPHA      = 1,
    parameter logic [7:0] FILL_CHAR  = 8'h20,
    localparam int        IW         = idx_w(NCHARS)
) (
    input  logic                px_clk,
    input  logic                rst_n,
    input  logic [STREAM_W-1:0] RGBStr_i,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    dyn_text_line_if.slave      bus,
`ifdef DYN_TEXT_CURSOR_EN
    input  logic [IW-1:0]       cursor_idx,
    input  logic                cursor_on,
`endif
    output logic [STREAM_W-1:0] RGBStr_o
);

    localparam int          CW     = GLYPH_W << SCALE_LOG2;
    localparam logic [31:0] LINE_W = 32'(NCHARS * CW);
    localparam logic [10:0] CELL_H = 11'(GLYPH_H << SCALE_LOG2);

    stream_t s_in;
    assign s_in = RGBStr_i;

    // ---------------- geometry (11-bit, no 10-bit wrap) ----------------
    logic [10:0]   rx, ry;
    logic          x_ge, y_ge, inside_c, cur_c;
    logic [IW-1:0] idx_c;
    logic [2:0]    gx_c, gy_c;
    logic [7:0]    rd_char;

    assign rx   = {1'b0, s_in.xc} - {1'b0, pos_x};
    assign ry   = {1'b0, s_in.yc} - {1'b0, pos_y};
    assign x_ge = (s_in.xc >= pos_x);
    assign y_ge = (s_in.yc >= pos_y);

    // LINE_W can exceed 11 bits for long lines, so compare at 32 bits.
    assign inside_c = s_in.active & x_ge & y_ge
                    & ({21'd0, rx} < LINE_W) & (ry < CELL_H);

    assign idx_c = IW'(rx >> (3 + SCALE_LOG2));
    assign gx_c  = 3'(rx >> SCALE_LOG2);
    assign gy_c  = 3'(ry >> SCALE_LOG2);

    dyn_text_buf #(
        .NCHARS    (NCHARS),
        .IW        (IW),
        .FILL_CHAR (FILL_CHAR)
    ) u_buf (
        .clk     (px_clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_char (bus.wr_char),
        .rd_addr (idx_c),
        .rd_char (rd_char)
    );

    // ---------------- optional blinking cursor ----------------
`ifdef DYN_TEXT_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       vs_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            vs_q      <= 1'b0;
        end else begin
            vs_q <= s_in.vs;
            if (s_in.vs && !vs_q) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    // Blink phase is bit 5: 32 frames off, 32 frames on.
    assign cur_c = cursor_on & frame_cnt[5] & inside_c & (idx_c == cursor_idx);
`else
    assign cur_c = 1'b0;
`endif

    // ---------------- S0: sample geometry, character, stream ----------------
    logic       s0_inside, s0_cur;
    logic [2:0] s0_gx, s0_gy;
    logic [7:0] s0_char;
    stream_t    s0_stream;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_inside <= 1'b0;
            s0_cur    <= 1'b0;
            s0_gx     <= '0;
            s0_gy     <= '0;
            s0_char   <= '0;
            s0_stream <= '0;
        end else begin
            s0_inside <= inside_c;
            s0_cur    <= cur_c;
            s0_gx     <= gx_c;
            s0_gy     <= gy_c;
            s0_stream <= s_in;
            if (inside_c) begin
                s0_char <= rd_char;
            end
        end
    end

    // ---------------- S1: font ROM address ----------------
    logic              s1_inside, s1_cur;
    logic [2:0]        s1_gx;
    stream_t           s1_stream;
    logic [ROM_AW-1:0] addr_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inside <= 1'b0;
            s1_cur    <= 1'b0;
            s1_gx     <= '0;
            s1_stream <= '0;
            addr_q    <= '0;
        end else begin
            s1_inside <= s0_inside;
            s1_cur    <= s0_cur;
            s1_gx     <= s0_gx;
            s1_stream <= s0_stream;
            // Hold the address outside the line so the ROM bus stays quiet.
            if (s0_inside) begin
                addr_q <= {s0_char, s0_gy};
            end
        end
    end

    assign bus.addr_rom = addr_q;

    // ---------------- S2: wait for the ROM ----------------
    logic       s2_inside, s2_cur;
    logic [2:0] s2_gx;
    stream_t    s2_stream;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_inside <= 1'b0;
            s2_cur    <= 1'b0;
            s2_gx     <= '0;
            s2_stream <= '0;
        end else begin
            s2_inside <= s1_inside;
            s2_cur    <= s1_cur;
            s2_gx     <= s1_gx;
            s2_stream <= s1_stream;
        end
    end

    // ---------------- S3: colour select ----------------
    logic    pix;
    stream_t out_nxt;

    always_comb begin
        pix     = bus.gline[s2_gx];
        out_nxt = s2_stream;
        if (s2_inside) begin
            if (s2_cur) begin
                out_nxt.rgb = pix ? COLOR_BG : COLOR_FG;
            end else if (pix) begin
                out_nxt.rgb = COLOR_FG;
            end else if (ALPHA == 0) begin
                out_nxt.rgb = COLOR_BG;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            RGBStr_o <= '0;
        end else begin
            RGBStr_o <= out_nxt;
        end
    end

endmodule

// File: tb/tb_dyn_text_line.sv
`timescale 1ns/1ps
module tb_dyn_text_line;
    import dyn_text_pkg::*;

    localparam int         NCHARS = 16;
    localparam int         SL     = 1;
    localparam int         IW     = idx_w(NCHARS);
    localparam int         CW     = 8 << SL;
    localparam int         LINE_W = NCHARS * CW;
    localparam int         CELL_H = 8 << SL;
    localparam logic [7:0] FILL   = 8'h20;
    localparam logic [2:0] FG     = 3'b110;
    localparam logic [2:0] BG     = 3'b001;

    // ---------------- clock / reset ----------------
    logic        px_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [25:0] rgb_i  = '0;
    logic [9:0]  pos_x  = '0;
    logic [9:0]  pos_y  = '0;
    logic [25:0] rgb_o, rgb_o_a0;
`ifdef DYN_TEXT_CURSOR_EN
    logic          cursor_on  = 1'b0;
    logic [IW-1:0] cursor_idx = '0;
`endif

    always #5 px_clk = ~px_clk;

    dyn_text_line_if #(.IW(IW)) bus ();
    dyn_text_line_if #(.IW(IW)) bus_a0 ();

    assign bus_a0.wr_en   = bus.wr_en;
    assign bus_a0.wr_addr = bus.wr_addr;
    assign bus_a0.wr_char = bus.wr_char;

    // Font ROM model: one-cycle synchronous read.
    logic [0:7] rom_mem [2048];
    always @(posedge px_clk) begin
        bus.gline    <= rom_mem[bus.addr_rom];
        bus_a0.gline <= rom_mem[bus_a0.addr_rom];
    end

    dyn_text_line #(.NCHARS(NCHARS), .SCALE_LOG2(SL), .ALPHA(1)) u_dut (
        .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(rgb_i),
        .pos_x(pos_x), .pos_y(pos_y), .bus(bus),
`ifdef DYN_TEXT_CURSOR_EN
        .cursor_idx(cursor_idx), .cursor_on(cursor_on),
`endif
        .RGBStr_o(rgb_o)
    );

    dyn_text_line #(.NCHARS(NCHARS), .SCALE_LOG2(SL), .ALPHA(0)) u_dut_a0 (
        .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(rgb_i),
        .pos_x(pos_x), .pos_y(pos_y), .bus(bus_a0),
`ifdef DYN_TEXT_CURSOR_EN
        .cursor_idx(cursor_idx), .cursor_on(cursor_on),
`endif
        .RGBStr_o(rgb_o_a0)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  text [NCHARS];
    int          vs_cnt;
    logic        prev_vs;
    logic [10:0] last_addr;
    logic [25:0] exp_q[$];
    logic [25:0] exp_a0_q[$];
    logic [10:0] exp_addr_q[$];
    int          checks = 0;
    int          errors = 0;

    // Pipeline after reset holds zeros: three empty output slots, one address slot.
    task automatic model_reset();
        for (int i = 0; i < NCHARS; i++) text[i] = FILL;
        vs_cnt    = 0;
        prev_vs   = 1'b0;
        last_addr = '0;
        exp_q.delete();
        exp_a0_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            exp_a0_q.push_back('0);
        end
        exp_addr_q.push_back('0);
    endtask

    function automatic logic [25:0] mk_px(input logic [2:0] rgb, input int xc, input int yc,
                                          input logic act);
        return {rgb, 10'(xc), 10'(yc), 1'b0, 1'b0, act};
    endfunction

    // Drives one pixel (and optional write) and scores the outputs of that edge.
    task automatic drive_pixel(input logic [25:0] s, input logic we, input logic [IW-1:0] wa,
                               input logic [7:0] wc, input string tag);
        int          xc, yc, rx, ry, idx, gx, gy;
        logic        ins, pix, cur;
        logic [2:0]  r1, r0;
        logic [10:0] a;
        logic [25:0] e1, e0;
        logic [10:0] ea;
        rgb_i       = s;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_char = wc;
        @(posedge px_clk);
        xc  = int'(s[XC_HI:XC_LO]);
        yc  = int'(s[YC_HI:YC_LO]);
        rx  = xc - int'(pos_x);
        ry  = yc - int'(pos_y);
        ins = s[ACTIVE] && rx >= 0 && ry >= 0 && rx < LINE_W && ry < CELL_H;
        r1  = s[RGB_HI:RGB_LO];
        r0  = r1;
        if (ins) begin
            idx = rx / CW;
            gx  = (rx / (1 << SL)) % 8;
            gy  = (ry / (1 << SL)) % 8;
            a   = {text[idx], 3'(gy)};
            last_addr = a;
            pix = rom_mem[a][gx];
            cur = 1'b0;
`ifdef DYN_TEXT_CURSOR_EN
            cur = cursor_on && ((vs_cnt % 64) >= 32) && (idx == int'(cursor_idx));
`endif
            if (cur) begin
                r1 = pix ? BG : FG;
                r0 = r1;
            end else if (pix) begin
                r1 = FG;
                r0 = FG;
            end else begin
                r0 = BG;
            end
        end
        exp_q.push_back({r1, s[22:0]});
        exp_a0_q.push_back({r0, s[22:0]});
        exp_addr_q.push_back(last_addr);
        if (s[VS] && !prev_vs) vs_cnt++;
        prev_vs = s[VS];
        if (we && int'(wa) < NCHARS) text[wa] = wc;
        @(negedge px_clk);
        bus.wr_en = 1'b0;
        e1 = exp_q.pop_front();
        e0 = exp_a0_q.pop_front();
        ea = exp_addr_q.pop_front();
        checks++;
        if (rgb_o !== e1) begin
            errors++;
            $display("FAIL %s stream_o: got %h expected %h", tag, rgb_o, e1);
        end
        checks++;
        if (rgb_o_a0 !== e0) begin
            errors++;
            $display("FAIL %s stream_o_alpha0: got %h expected %h", tag, rgb_o_a0, e0);
        end
        checks++;
        if (bus.addr_rom !== ea) begin
            errors++;
            $display("FAIL %s addr_rom: got %h expected %h", tag, bus.addr_rom, ea);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive_pixel('0, 1'b0, '0, 8'h00, tag);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rgb_i = 26'($urandom);
            @(posedge px_clk);
            @(negedge px_clk);
            checks++;
            if (rgb_o !== '0 || rgb_o_a0 !== '0) begin
                errors++;
                $display("FAIL reset_out: got %h/%h expected 0", rgb_o, rgb_o_a0);
            end
            checks++;
            if (bus.addr_rom !== '0) begin
                errors++;
                $display("FAIL reset_addr: got %h expected 0", bus.addr_rom);
            end
        end
        model_reset();
        rst_n = 1'b1;
        pos_x = 10'd100;
        pos_y = 10'd50;
        // Every cell reads the fill character after reset.
        for (int i = 0; i < NCHARS; i++) begin
            drive_pixel(mk_px(3'b000, 100 + i * CW, 52, 1'b1), 1'b0, '0, 8'h00, "reset_fill");
            idle(1, "reset_fill");
            checks++;
            if (bus.addr_rom !== {FILL, 3'd1}) begin
                errors++;
                $display("FAIL reset_fill cell %0d: got %h expected %h", i, bus.addr_rom,
                         {FILL, 3'd1});
            end
        end
        idle(3, "reset_fill");
    endtask

    task automatic test_basic();
        drive_pixel('0, 1'b1, IW'(0), 8'h41, "basic_wr");
        drive_pixel(mk_px(3'b010, 100, 50, 1'b1), 1'b0, '0, 8'h00, "basic");
        idle(1, "basic");
        checks++;
        if (bus.addr_rom !== 11'h208) begin
            errors++;
            $display("FAIL basic_addr: got %h expected 208", bus.addr_rom);
        end
        idle(2, "basic");
        checks++;
        if (rgb_o[25:23] !== FG || rgb_o_a0[25:23] !== FG) begin
            errors++;
            $display("FAIL basic_fg: got %b/%b expected %b", rgb_o[25:23], rgb_o_a0[25:23], FG);
        end
    endtask

    task automatic test_cell_index();
        drive_pixel('0, 1'b1, IW'(1), 8'h33, "cell_wr");
        drive_pixel(mk_px(3'b100, 117, 53, 1'b1), 1'b0, '0, 8'h00, "cell");
        idle(1, "cell");
        checks++;
        if (bus.addr_rom !== {8'h33, 3'd1}) begin
            errors++;
            $display("FAIL cell_addr: got %h expected %h", bus.addr_rom, {8'h33, 3'd1});
        end
        idle(3, "cell");
    endtask

    task automatic test_outside();
        logic [25:0] px [3];
        px[0] = mk_px(3'b101, 99, 50, 1'b1);
        px[1] = mk_px(3'b101, 100 + NCHARS * CW, 50, 1'b1);
        px[2] = mk_px(3'b101, 110, 55, 1'b0) | 26'b110;
        for (int i = 0; i < 3; i++) begin
            drive_pixel(px[i], 1'b0, '0, 8'h00, "outside");
            idle(3, "outside");
            checks++;
            if (rgb_o !== px[i] || rgb_o_a0 !== px[i]) begin
                errors++;
                $display("FAIL outside case %0d: got %h/%h expected %h", i, rgb_o, rgb_o_a0, px[i]);
            end
        end
    endtask

    task automatic test_alpha();
        // Cell 0 holds 8'h41; ROM row 0 has only the leftmost bit set, gx=1 is clear.
        drive_pixel(mk_px(3'b011, 102, 50, 1'b1), 1'b0, '0, 8'h00, "alpha");
        idle(3, "alpha");
        checks++;
        if (rgb_o[25:23] !== 3'b011) begin
            errors++;
            $display("FAIL alpha1_bg: got %b expected 011", rgb_o[25:23]);
        end
        checks++;
        if (rgb_o_a0[25:23] !== BG) begin
            errors++;
            $display("FAIL alpha0_bg: got %b expected %b", rgb_o_a0[25:23], BG);
        end
    endtask

    task automatic test_write_collision();
        drive_pixel(mk_px(3'b000, 132, 50, 1'b1), 1'b1, IW'(2), 8'h55, "collide");
        idle(1, "collide");
        checks++;
        if (bus.addr_rom !== 11'h100) begin
            errors++;
            $display("FAIL collide_old: got %h expected 100", bus.addr_rom);
        end
        drive_pixel(mk_px(3'b000, 132, 50, 1'b1), 1'b0, '0, 8'h00, "collide");
        idle(1, "collide");
        checks++;
        if (bus.addr_rom !== 11'h2A8) begin
            errors++;
            $display("FAIL collide_new: got %h expected 2a8", bus.addr_rom);
        end
        idle(2, "collide");
    endtask

    task automatic test_random(input int n);
        int xc, yc;
        for (int i = 0; i < n; i++) begin
            if (i % 100 == 0) begin
                case ((i / 100) % 4)
                    0: begin pos_x = 10'd100;  pos_y = 10'd50;   end
                    1: begin pos_x = 10'd1000; pos_y = 10'd40;   end
                    2: begin pos_x = 10'd3;    pos_y = 10'd1018; end
                    default: begin pos_x = 10'($urandom); pos_y = 10'($urandom); end
                endcase
            end
            xc = int'(pos_x) + int'($urandom_range(0, LINE_W + 16)) - 8;
            yc = int'(pos_y) + int'($urandom_range(0, CELL_H + 4)) - 2;
            if (xc < 0) xc = 0;
            if (xc > 1023) xc = int'($urandom_range(0, 40));
            if (yc < 0) yc = 0;
            if (yc > 1023) yc = int'($urandom_range(0, 10));
            drive_pixel({3'($urandom), 10'(xc), 10'(yc), 2'($urandom),
                         1'($urandom_range(0, 7) != 0)},
                        1'($urandom_range(0, 3) == 0), IW'($urandom), 8'($urandom), "random");
        end
        idle(3, "random");
    endtask

    task automatic test_reset_mid();
        pos_x = 10'd100;
        pos_y = 10'd50;
        drive_pixel(mk_px(3'b111, 140, 51, 1'b1), 1'b1, IW'(5), 8'h7E, "mid");
        drive_pixel(mk_px(3'b111, 100, 51, 1'b1), 1'b0, '0, 8'h00, "mid");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rgb_o !== '0 || rgb_o_a0 !== '0 || bus.addr_rom !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got %h/%h addr %h expected 0", rgb_o, rgb_o_a0,
                     bus.addr_rom);
        end
        @(negedge px_clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < NCHARS; i++)
            drive_pixel(mk_px(3'b010, 100 + i * CW + 2 * i % CW, 50 + i % CELL_H, 1'b1),
                        1'b0, '0, 8'h00, "mid_refill");
        idle(3, "mid_refill");
    endtask

`ifdef DYN_TEXT_CURSOR_EN
    task automatic test_cursor();
        pos_x      = 10'd100;
        pos_y      = 10'd50;
        cursor_on  = 1'b1;
        cursor_idx = IW'(2);
        drive_pixel('0, 1'b1, IW'(2), 8'h41, "cursor_wr");
        drive_pixel('0, 1'b1, IW'(3), 8'h41, "cursor_wr");
        for (int k = 0; k < 64 && (vs_cnt % 64) < 32; k++) begin
            drive_pixel(26'b010, 1'b0, '0, 8'h00, "cursor_vs");
            drive_pixel(26'b000, 1'b0, '0, 8'h00, "cursor_vs");
        end
        for (int x = 100 + CW; x < 100 + 4 * CW; x++)
            drive_pixel(mk_px(3'b011, x, 50, 1'b1), 1'b0, '0, 8'h00, "cursor_scan");
        drive_pixel(mk_px(3'b011, 132, 50, 1'b1), 1'b0, '0, 8'h00, "cursor_cell");
        idle(3, "cursor_cell");
        checks++;
        if (rgb_o[25:23] !== BG) begin
            errors++;
            $display("FAIL cursor_swap: got %b expected %b", rgb_o[25:23], BG);
        end
        drive_pixel(mk_px(3'b011, 148, 50, 1'b1), 1'b0, '0, 8'h00, "cursor_next");
        idle(3, "cursor_next");
        checks++;
        if (rgb_o[25:23] !== FG) begin
            errors++;
            $display("FAIL cursor_other_cell: got %b expected %b", rgb_o[25:23], FG);
        end
        cursor_on = 1'b0;
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_char = '0;
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[11'h208] = 8'b1000_0000;
        model_reset();
        test_reset();
        test_basic();
        test_cell_index();
        test_outside();
        test_alpha();
        test_write_collision();
        test_random(400);
        test_reset_mid();
        test_random(200);
`ifdef DYN_TEXT_CURSOR_EN
        test_cursor();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
